// File: rtl/mem_bus_ctrl_pkg.sv
// mem_bus_ctrl_pkg: memory op codes, stall levels and access-size helper
package mem_bus_ctrl_pkg;
  typedef enum logic [2:0] {
    MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW, MEM_OP_SB, MEM_OP_SH, MEM_OP_SW
  } mem_op_e;
  localparam logic STALL_REQ = 1'b1;
  localparam logic NO_STALL = 1'b0;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  function automatic logic [1:0] mem_size(input logic [2:0] op);
    return (op == MEM_OP_LB || op == MEM_OP_LBU || op == MEM_OP_SB) ? SZ_B :
           (op == MEM_OP_LH || op == MEM_OP_LHU || op == MEM_OP_SH) ? SZ_H : SZ_W;
  endfunction
  function automatic logic is_store(input logic [2:0] op);
    return op == MEM_OP_SB || op == MEM_OP_SH || op == MEM_OP_SW;
  endfunction
endpackage

// File: rtl/mem_bus_ctrl_lane_fmt.sv
// mem_lane_fmt: big-endian byte-lane formatting for stores and extension for loads
module mem_lane_fmt
  import mem_bus_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [2:0]  ld_op,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata_lane,
  output logic        misaligned,
  output logic [31:0] ld_data
);
  logic [1:0]  sz;
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    sz = mem_size(op);
    sel = sz == SZ_B ? 4'b1000 >> off : sz == SZ_H ? (off[1] ? 4'b0011 : 4'b1100) : 4'b1111;
    wdata_lane = sz == SZ_B ? {4{wdata[7:0]}} : sz == SZ_H ? {2{wdata[15:0]}} : wdata;
    misaligned = sz == SZ_H ? off[0] : sz == SZ_W ? |off : 1'b0;
    // offset 0 is the most significant byte, so ~off selects the lane from the top
    b = rdata[{~ld_off, 3'b000} +: 8];
    h = ld_off[1] ? rdata[15:0] : rdata[31:16];
    ld_data = ld_op == MEM_OP_LB  ? {{24{b[7]}}, b} :
              ld_op == MEM_OP_LBU ? {24'b0, b} :
              ld_op == MEM_OP_LH  ? {{16{h[15]}}, h} :
              ld_op == MEM_OP_LHU ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: sequences MEM-stage loads/stores onto a req/ack bus with stall, align and timeout
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        flush_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        stallreq_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        align_exc_o,
  output logic        bus_err_o
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE, S_DRAIN} state_e;
  state_e state, nxt;
  logic [CW-1:0] cnt;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic [3:0]  sel;
  logic [31:0] wlane, ld_data;
  logic        misaligned, accept, timeout, ack;
  mem_lane_fmt u_fmt (
    .op(op_i), .off(addr_i[1:0]), .wdata(wdata_i),
    .ld_op(op_q), .ld_off(off_q), .rdata(bus_rdata_i),
    .sel(sel), .wdata_lane(wlane), .misaligned(misaligned), .ld_data(ld_data)
  );
  always_comb begin
    accept = state == S_IDLE && req_i && !flush_i && !misaligned;
    timeout = cnt == CW'(TIMEOUT_CYC - 1);
    ack = bus_ack_i;
    bus_req_o = state == S_BUS || state == S_DRAIN;
    done_o = state == S_DONE;
    align_exc_o = state == S_IDLE && req_i && !flush_i && misaligned;
    stallreq_o = state == S_IDLE ? (accept ? STALL_REQ : NO_STALL) :
                 state == S_BUS ? STALL_REQ : state == S_DRAIN ? req_i : NO_STALL;
    nxt = state;
    case (state)
      S_IDLE:  nxt = accept ? S_BUS : S_IDLE;
      // a flush aborts silently; an outstanding request is drained unless it already ends now
      S_BUS:   nxt = flush_i ? ((ack || timeout) ? S_IDLE : S_DRAIN) : (ack || timeout) ? S_DONE : S_BUS;
      S_DONE:  nxt = S_IDLE;
      S_DRAIN: nxt = (ack || timeout) ? S_IDLE : S_DRAIN;
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt <= '0;
      op_q <= '0;
      off_q <= '0;
      bus_we_o <= 1'b0;
      bus_addr_o <= '0;
      bus_sel_o <= '0;
      bus_wdata_o <= '0;
      rdata_o <= '0;
      bus_err_o <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= bus_req_o ? cnt + 1'b1 : '0;
      if (accept) begin
        op_q <= op_i;
        off_q <= addr_i[1:0];
        bus_we_o <= is_store(op_i);
        bus_addr_o <= {addr_i[31:2], 2'b00};
        bus_sel_o <= sel;
        bus_wdata_o <= wlane;
        rdata_o <= '0;
        bus_err_o <= 1'b0;
      end
      if (state == S_BUS && ack) begin
        rdata_o <= bus_we_o ? '0 : ld_data;
        bus_err_o <= 1'b0;
      end else if (state == S_BUS && timeout) begin
        rdata_o <= '0;
        bus_err_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed scoreboard bench for mem_bus_ctrl with an 8-cycle timeout
module tb_mem_bus_ctrl;
  import mem_bus_ctrl_pkg::*;
  logic clk = 0, rst = 0, req_i = 0, flush_i = 0, bus_ack_i = 0;
  logic [2:0] op_i = 0;
  logic [31:0] addr_i = 0, wdata_i = 0, bus_rdata_i = 0;
  logic bus_req_o, bus_we_o, stallreq_o, done_o, align_exc_o, bus_err_o;
  logic [31:0] bus_addr_o, bus_wdata_o, rdata_o;
  logic [3:0] bus_sel_o;
  typedef struct packed {logic [31:0] rdata; logic err;} exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_err = 0, req_cnt = 0, done_cnt = 0;

  mem_bus_ctrl #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .flush_i(flush_i), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i),
    .bus_rdata_i(bus_rdata_i), .stallreq_o(stallreq_o), .done_o(done_o), .rdata_o(rdata_o),
    .align_exc_o(align_exc_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus_req_o) req_cnt++;
    if (done_o) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) chk("sb_unexpected_done", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("sb_rdata", rdata_o, e.rdata);
        chk("sb_err", {31'b0, bus_err_o}, {31'b0, e.err});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input int delay, input logic [31:0] rd,
                       input logic [3:0] sel, input logic [31:0] bwd, input logic [31:0] exp_rd,
                       input logic exp_err, input int exp_cyc);
    int i = 0;
    req_i = 1; op_i = op; addr_i = addr; wdata_i = wd;
    #1;
    chk({tag, "_stall_accept"}, {31'b0, stallreq_o}, 32'd1);
    chk({tag, "_no_align"}, {31'b0, align_exc_o}, 32'd0);
    sb.push_back({exp_rd, exp_err});
    req_cnt = 0;
    cyc();
    chk({tag, "_bus_req"}, {31'b0, bus_req_o}, 32'd1);
    chk({tag, "_we"}, {31'b0, bus_we_o}, {31'b0, is_store(op)});
    chk({tag, "_addr"}, bus_addr_o, {addr[31:2], 2'b00});
    chk({tag, "_sel"}, {28'b0, bus_sel_o}, {28'b0, sel});
    if (is_store(op)) chk({tag, "_wdata"}, bus_wdata_o, bwd);
    while (!done_o && i < 20) begin
      i++;
      bus_ack_i = (i == delay);
      bus_rdata_i = rd;
      cyc();
    end
    bus_ack_i = 0;
    chk({tag, "_done"}, {31'b0, done_o}, 32'd1);
    chk({tag, "_stall_done"}, {31'b0, stallreq_o}, 32'd0);
    chk({tag, "_req_cycles"}, req_cnt, exp_cyc);
    req_i = 0;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    cyc(); cyc();
    chk("rst_bus_req", {31'b0, bus_req_o}, 32'd0);
    chk("rst_done", {31'b0, done_o}, 32'd0);
    chk("rst_stall", {31'b0, stallreq_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_err", {31'b0, bus_err_o}, 32'd0);
    rst = 1;
    cyc();
    do_op("lw", MEM_OP_LW, 32'h100, 0, 3, 32'h12345678, 4'b1111, 0, 32'h12345678, 0, 3);
    do_op("lb", MEM_OP_LB, 32'h103, 0, 1, 32'h000000F0, 4'b0001, 0, 32'hFFFFFFF0, 0, 1);
    do_op("lbu", MEM_OP_LBU, 32'h103, 0, 1, 32'h000000F0, 4'b0001, 0, 32'h000000F0, 0, 1);
    do_op("sh", MEM_OP_SH, 32'h102, 32'hAAAABEEF, 2, 32'hFFFFFFFF, 4'b0011, 32'hBEEFBEEF, 0, 0, 2);
    do_op("lh", MEM_OP_LH, 32'h200, 0, 1, 32'h8001FFFF, 4'b1100, 0, 32'hFFFF8001, 0, 1);
    do_op("lhu", MEM_OP_LHU, 32'h202, 0, 2, 32'h1234ABCD, 4'b0011, 0, 32'h0000ABCD, 0, 2);
    do_op("sb", MEM_OP_SB, 32'h301, 32'h12345655, 1, 0, 4'b0100, 32'h55555555, 0, 0, 1);
    do_op("lb1", MEM_OP_LB, 32'h301, 0, 1, 32'h007F0000, 4'b0100, 0, 32'h0000007F, 0, 1);
    // misaligned word and half: exception only, no bus activity
    req_i = 1; op_i = MEM_OP_LW; addr_i = 32'h102;
    #1;
    chk("mis_lw_exc", {31'b0, align_exc_o}, 32'd1);
    chk("mis_lw_stall", {31'b0, stallreq_o}, 32'd0);
    op_i = MEM_OP_LH; addr_i = 32'h101;
    #1;
    chk("mis_lh_exc", {31'b0, align_exc_o}, 32'd1);
    cyc();
    chk("mis_no_bus", {31'b0, bus_req_o}, 32'd0);
    req_i = 0;
    cyc();
    do_op("tmo", MEM_OP_LW, 32'h400, 0, 0, 32'hDEADBEEF, 4'b1111, 0, 0, 1, 8);
    // flush in BUS, ack two cycles later: drained with no completion
    d0 = done_cnt;
    req_i = 1; op_i = MEM_OP_LW; addr_i = 32'h500;
    cyc();
    flush_i = 1;
    cyc();
    flush_i = 0; req_i = 0;
    #1;
    chk("drain_req", {31'b0, bus_req_o}, 32'd1);
    chk("drain_stall", {31'b0, stallreq_o}, 32'd0);
    cyc();
    bus_ack_i = 1;
    cyc();
    bus_ack_i = 0;
    chk("drain_idle", {31'b0, bus_req_o}, 32'd0);
    cyc();
    chk("drain_no_done", done_cnt, d0);
    // flush in IDLE with a misaligned op: ignored
    req_i = 1; flush_i = 1; op_i = MEM_OP_SW; addr_i = 32'h601;
    #1;
    chk("flush_idle_exc", {31'b0, align_exc_o}, 32'd0);
    chk("flush_idle_stall", {31'b0, stallreq_o}, 32'd0);
    cyc();
    chk("flush_idle_bus", {31'b0, bus_req_o}, 32'd0);
    flush_i = 0; req_i = 0;
    // reset mid-BUS, then a store completes normally
    req_i = 1; op_i = MEM_OP_SW; addr_i = 32'h700; wdata_i = 32'h11111111;
    cyc();
    chk("rbus_req", {31'b0, bus_req_o}, 32'd1);
    rst = 0;
    cyc();
    chk("rbus_drop", {31'b0, bus_req_o}, 32'd0);
    rst = 1; req_i = 0;
    cyc();
    do_op("sw", MEM_OP_SW, 32'h104, 32'hCAFEF00D, 1, 32'h5A5A5A5A, 4'b1111, 32'hCAFEF00D, 0, 0, 1);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
